// File: rtl/controle_troco.sv
// controle_troco: change/refund coin ejector sequencer.
//
// Started by the vending FSM with a one-cycle `iniciar` pulse. It works out the
// change (or the full refund), then pays it out one coin at a time, largest coin
// first, through a four-phase req/ack handshake with the coin ejector. It keeps
// two coin stocks (value 1 and value 2). When the change cannot be completed it
// raises a sticky `erro` flag.
//
// Optional feature, controlled by the macro CONTROLE_TROCO_TIMEOUT_EN:
//   When the macro is defined, a request that waits ACK_TIMEOUT cycles without an
//   ack is abandoned and the transaction ends in error. Without the macro, PEDE
//   waits for the ack indefinitely.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   iniciar          start pulse; honoured only when idle
//   devolver_tudo    1 = refund valor_acumulado, 0 = return change
//   valor_acumulado  coin total, sampled on an accepted iniciar
//   valor_produto    product price, sampled on an accepted iniciar
//   ack_ejetor       ejector acknowledge (four-phase)
//   repor            reload both stocks to ESTOQUE_INI; honoured only when idle
//   eject_req        request one coin ejection
//   eject_tipo       0 = coin of value 1, 1 = coin of value 2
//   ocupado          high in every state except idle
//   concluido        one-cycle pulse at the end of each transaction
//   erro             sticky failure flag, cleared by the next accepted iniciar
//   troco_restante   change still to be dispensed
//   estoque_1        value-1 coins in stock
//   estoque_2        value-2 coins in stock

module controle_troco #(
    parameter int unsigned VAL_W       = 4,
    parameter int unsigned PRECO_W     = 3,
    parameter int unsigned ESTOQUE_W   = 4,
    parameter int unsigned ESTOQUE_INI = 8
`ifdef CONTROLE_TROCO_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TIMEOUT = 15
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 devolver_tudo,
    input  logic [VAL_W-1:0]     valor_acumulado,
    input  logic [PRECO_W-1:0]   valor_produto,
    input  logic                 ack_ejetor,
    input  logic                 repor,
    output logic                 eject_req,
    output logic                 eject_tipo,
    output logic                 ocupado,
    output logic                 concluido,
    output logic                 erro,
    output logic [VAL_W-1:0]     troco_restante,
    output logic [ESTOQUE_W-1:0] estoque_1,
    output logic [ESTOQUE_W-1:0] estoque_2
);

    typedef enum logic [2:0] {
        StOcioso,
        StSeleciona,
        StPede,
        StSolta,
        StFim,
        StErro
    } estado_e;

    localparam logic [ESTOQUE_W-1:0] EstoqueIni = ESTOQUE_W'(ESTOQUE_INI);
    localparam logic [ESTOQUE_W-1:0] EstoqueUm  = ESTOQUE_W'(1);
    localparam logic [VAL_W-1:0]     ValUm      = VAL_W'(1);
    localparam logic [VAL_W-1:0]     ValDois    = VAL_W'(2);

    // Width used to compare the coin total against the price without losing bits.
    localparam int unsigned CmpW = (VAL_W > PRECO_W) ? VAL_W : PRECO_W;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    estado_e                estado_q, estado_d;
    logic [VAL_W-1:0]       troco_q, troco_d;
    logic [ESTOQUE_W-1:0]   estoque1_q, estoque1_d;
    logic [ESTOQUE_W-1:0]   estoque2_q, estoque2_d;
    logic                   eject_req_q, eject_req_d;
    logic                   eject_tipo_q, eject_tipo_d;
    logic                   concluido_q, concluido_d;
    logic                   erro_q, erro_d;
    logic                   ocupado_q, ocupado_d;

    // ------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------
    logic [CmpW-1:0]  valor_ext;
    logic [CmpW-1:0]  preco_ext;
    logic [VAL_W-1:0] troco_inicial;
    logic             usa_moeda_2;
    logic             usa_moeda_1;
    logic             tmo_expira;

    assign valor_ext = CmpW'(valor_acumulado);
    assign preco_ext = CmpW'(valor_produto);

    // An underpaid sale is handled as a full refund.
    always_comb begin
        troco_inicial = valor_acumulado;
        if (!devolver_tudo && (valor_ext >= preco_ext)) begin
            troco_inicial = VAL_W'(valor_ext - preco_ext);
        end
    end

    assign usa_moeda_2 = (troco_q >= ValDois) && (estoque2_q != '0);
    assign usa_moeda_1 = (estoque1_q != '0);

`ifdef CONTROLE_TROCO_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // The counter reads k on the (k+1)-th PEDE cycle, so the request is abandoned
    // after exactly ACK_TIMEOUT cycles with eject_req high. An ack on that last
    // cycle still wins.
    assign tmo_expira = (estado_q == StPede) && !ack_ejetor &&
                        (tmo_q == TmoW'(ACK_TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q;
        if ((estado_d == StPede) && (estado_q != StPede)) begin
            tmo_d = '0;
        end else if (estado_q == StPede) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_expira = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Process 1: state register (plus registered datapath/outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= StOcioso;
            troco_q      <= '0;
            estoque1_q   <= EstoqueIni;
            estoque2_q   <= EstoqueIni;
            eject_req_q  <= 1'b0;
            eject_tipo_q <= 1'b0;
            concluido_q  <= 1'b0;
            erro_q       <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            troco_q      <= troco_d;
            estoque1_q   <= estoque1_d;
            estoque2_q   <= estoque2_d;
            eject_req_q  <= eject_req_d;
            eject_tipo_q <= eject_tipo_d;
            concluido_q  <= concluido_d;
            erro_q       <= erro_d;
            ocupado_q    <= ocupado_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StOcioso: begin
                if (iniciar) begin
                    estado_d = StSeleciona;
                end
            end
            StSeleciona: begin
                if (troco_q == '0) begin
                    estado_d = StFim;
                end else if (usa_moeda_2 || usa_moeda_1) begin
                    estado_d = StPede;
                end else begin
                    estado_d = StErro;
                end
            end
            StPede: begin
                if (ack_ejetor) begin
                    estado_d = StSolta;
                end else if (tmo_expira) begin
                    estado_d = StErro;
                end
            end
            StSolta: begin
                if (!ack_ejetor) begin
                    estado_d = StSeleciona;
                end
            end
            StFim:   estado_d = StOcioso;
            StErro:  estado_d = StOcioso;
            default: estado_d = StOcioso;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs and datapath. Outputs are registered, so they are
    // decoded from the state being entered rather than the current one.
    // ------------------------------------------------------------------
    always_comb begin
        troco_d      = troco_q;
        estoque1_d   = estoque1_q;
        estoque2_d   = estoque2_q;
        eject_tipo_d = eject_tipo_q;
        erro_d       = erro_q;
        eject_req_d  = (estado_d == StPede);
        concluido_d  = (estado_d == StFim) || (estado_d == StErro);
        ocupado_d    = (estado_d != StOcioso);

        unique case (estado_q)
            StOcioso: begin
                // Reload and start may coincide; SELECIONA then sees full stocks.
                if (repor) begin
                    estoque1_d = EstoqueIni;
                    estoque2_d = EstoqueIni;
                end
                if (iniciar) begin
                    erro_d  = 1'b0;
                    troco_d = troco_inicial;
                end
            end
            StSeleciona: begin
                if (estado_d == StPede) begin
                    eject_tipo_d = usa_moeda_2;
                end
            end
            StPede: begin
                if (ack_ejetor) begin
                    if (eject_tipo_q) begin
                        troco_d    = troco_q - ValDois;
                        estoque2_d = estoque2_q - EstoqueUm;
                    end else begin
                        troco_d    = troco_q - ValUm;
                        estoque1_d = estoque1_q - EstoqueUm;
                    end
                end
            end
            default: ;
        endcase

        if (estado_d == StErro) begin
            erro_d = 1'b1;
        end
    end

    assign eject_req      = eject_req_q;
    assign eject_tipo     = eject_tipo_q;
    assign ocupado        = ocupado_q;
    assign concluido      = concluido_q;
    assign erro           = erro_q;
    assign troco_restante = troco_q;
    assign estoque_1      = estoque1_q;
    assign estoque_2      = estoque2_q;

endmodule

// File: tb/tb_controle_troco.sv
// Bench for controle_troco: directed steps followed by randomized transactions,
// each checked against a greedy coin-payout model kept in the bench.

module tb_controle_troco;

    localparam int unsigned VAL_W       = 4;
    localparam int unsigned PRECO_W     = 3;
    localparam int unsigned ESTOQUE_W   = 4;
    localparam int unsigned ESTOQUE_INI = 8;
`ifdef CONTROLE_TROCO_TIMEOUT_EN
    localparam int unsigned ACK_TIMEOUT = 15;
`endif
    localparam int Budget = 600;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 iniciar = 1'b0;
    logic                 devolver_tudo = 1'b0;
    logic [VAL_W-1:0]     valor_acumulado = '0;
    logic [PRECO_W-1:0]   valor_produto = '0;
    logic                 ack_ejetor = 1'b0;
    logic                 repor = 1'b0;
    logic                 eject_req;
    logic                 eject_tipo;
    logic                 ocupado;
    logic                 concluido;
    logic                 erro;
    logic [VAL_W-1:0]     troco_restante;
    logic [ESTOQUE_W-1:0] estoque_1;
    logic [ESTOQUE_W-1:0] estoque_2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_s1   = ESTOQUE_INI;
    int m_s2   = ESTOQUE_INI;

    controle_troco #(
        .VAL_W       (VAL_W),
        .PRECO_W     (PRECO_W),
        .ESTOQUE_W   (ESTOQUE_W),
        .ESTOQUE_INI (ESTOQUE_INI)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .iniciar         (iniciar),
        .devolver_tudo   (devolver_tudo),
        .valor_acumulado (valor_acumulado),
        .valor_produto   (valor_produto),
        .ack_ejetor      (ack_ejetor),
        .repor           (repor),
        .eject_req       (eject_req),
        .eject_tipo      (eject_tipo),
        .ocupado         (ocupado),
        .concluido       (concluido),
        .erro            (erro),
        .troco_restante  (troco_restante),
        .estoque_1       (estoque_1),
        .estoque_2       (estoque_2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; start/reload inputs are one-cycle pulses.
    task automatic step();
        @(negedge clk);
        cyc++;
        iniciar = 1'b0;
        repor   = 1'b0;
    endtask

    // One complete transaction. Called and returns just after a falling edge.
    task automatic run_txn(input logic dev, input int val, input int pre, input logic rep,
                           input logic disturb, input logic stall);
        int   t, rem, s1, s2, n_exp, ncoin, cnt, run, exp_tipo;
        int   coins[$];
        logic exp_err;

        // Reference: reload, price rule, then greedy payout, value-2 coins first.
        if (rep) begin
            m_s1 = ESTOQUE_INI;
            m_s2 = ESTOQUE_INI;
        end
        t = (dev || val < pre) ? val : val - pre;
        rem = t;
        s1 = m_s1;
        s2 = m_s2;
        exp_err = 1'b0;
        while (rem > 0) begin
            if (rem >= 2 && s2 > 0) begin
                coins.push_back(2); rem -= 2; s2--;
            end else if (s1 > 0) begin
                coins.push_back(1); rem -= 1; s1--;
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
        n_exp = coins.size();
`ifdef CONTROLE_TROCO_TIMEOUT_EN
        // A never-acked first request abandons the sale with nothing paid.
        if (stall && coins.size() > 0) begin
            n_exp = 0; rem = t; s1 = m_s1; s2 = m_s2; exp_err = 1'b1;
        end
`endif

        iniciar         = 1'b1;
        devolver_tudo   = dev;
        valor_acumulado = VAL_W'(val);
        valor_produto   = PRECO_W'(pre);
        repor           = rep;
        cyc = 0;
        step();
        check("ocupado_start", ocupado, 1);
        if (disturb) begin
            iniciar         = 1'b1;
            repor           = 1'b1;
            devolver_tudo   = ~dev;
            valor_acumulado = VAL_W'($urandom_range(0, 15));
        end

        ncoin = 0;
        run   = t;
        while (!concluido && cyc < Budget) begin
            if (eject_req) begin
                exp_tipo = (ncoin < coins.size() && coins[ncoin] == 2) ? 1 : 0;
                if (ncoin == 0) check("lat_req", cyc, 2);
                if (ncoin < coins.size()) check("tipo", eject_tipo, exp_tipo);
                else check("extra_coin", ncoin, coins.size());
                if (stall && ncoin == 0) begin
                    cnt = 0;
`ifdef CONTROLE_TROCO_TIMEOUT_EN
                    while (eject_req && cnt < 200) begin cnt++; step(); end
                    check("timeout_len", cnt, ACK_TIMEOUT);
                    continue;
`else
                    while (eject_req && cnt < 120) begin cnt++; step(); end
                    check("no_timeout_hold", eject_req, 1);
                    check("no_timeout_cnt", cnt, 120);
`endif
                end
                repeat ($urandom_range(0, 3)) begin
                    step();
                    check("req_hold", eject_req, 1);
                    check("tipo_stable", eject_tipo, exp_tipo);
                end
                ack_ejetor = 1'b1;
                step();
                check("req_drop", eject_req, 0);
                if (ncoin < coins.size()) run -= coins[ncoin];
                check("troco_run", troco_restante, run);
                repeat ($urandom_range(0, 2)) begin
                    step();
                    check("solta_hold", eject_req, 0);
                end
                ack_ejetor = 1'b0;
                step();
                ncoin++;
                continue;
            end
            step();
        end

        check("concluido", concluido, 1);
        if (t == 0) check("lat_zero", cyc, 2);
        check("coins", ncoin, n_exp);
        check("erro", erro, exp_err);
        check("troco_fim", troco_restante, rem);
        check("estoque_1", estoque_1, s1);
        check("estoque_2", estoque_2, s2);
        check("req_fim", eject_req, 0);
        step();
        check("pulse_end", concluido, 0);
        check("idle", ocupado, 0);
        check("erro_sticky", erro, exp_err);
        m_s1 = s1;
        m_s2 = s2;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_req", eject_req, 0);
        check("rst_tipo", eject_tipo, 0);
        check("rst_concluido", concluido, 0);
        check("rst_erro", erro, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_troco", troco_restante, 0);
        check("rst_est1", estoque_1, ESTOQUE_INI);
        check("rst_est2", estoque_2, ESTOQUE_INI);

        // Change 4 -> two value-2 coins
        run_txn(1'b0, 7, 3, 1'b0, 1'b0, 1'b0);
        // Exact payment: no coins, concluido 2 cycles after iniciar
        run_txn(1'b0, 5, 5, 1'b0, 1'b0, 1'b0);
        // Drain value-2 stock, then refund 5 in value-1 coins
        run_txn(1'b1, 12, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
        // Drain value-1 stock, then an unpayable sale, then erro is cleared
        run_txn(1'b1, 3, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 3, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Reload together with start on empty stocks
        run_txn(1'b0, 7, 3, 1'b1, 1'b0, 1'b0);
        // Ejector never answers the first request
        run_txn(1'b0, 3, 1, 1'b0, 1'b0, 1'b1);
        // Start and reload pulsed while busy are ignored
        run_txn(1'b0, 9, 2, 1'b0, 1'b1, 1'b0);
        // Underpaid sale is refunded in full
        run_txn(1'b0, 2, 6, 1'b0, 1'b0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 7),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a request aborts with no concluido pulse
        iniciar         = 1'b1;
        devolver_tudo   = 1'b1;
        valor_acumulado = VAL_W'(6);
        repor           = 1'b1;
        step();
        step();
        check("pre_reset_req", eject_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_req", eject_req, 0);
        check("abort_ocupado", ocupado, 0);
        check("abort_concluido", concluido, 0);
        check("abort_troco", troco_restante, 0);
        check("abort_est1", estoque_1, ESTOQUE_INI);
        check("abort_est2", estoque_2, ESTOQUE_INI);
        step();
        check("abort_no_pulse", concluido, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
